btn_conditioner: RTL

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 64 ++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronize and debounce N buttons, emit press/release pulses and optional toggle.
// Define BTN_TOGGLE_EN to build the press-toggled btn_toggle output; otherwise it is tied to 0.
module btn_conditioner #(
  parameter int N      = 3,
  parameter int DB_CNT = 1000000,
  parameter int CNT_W  = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release,
  output logic [N-1:0] btn_toggle
);
  typedef enum logic {STABLE_LO = 1'b0, STABLE_HI = 1'b1} state_t;
  logic [N-1:0] sync0, sync1;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= btn_raw;
      sync1 <= sync0;
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic differ, flip, press, release_p;
    always_comb begin
      differ   = sync1[i] != (state == STABLE_HI);
      flip     = differ && (cnt == CNT_W'(DB_CNT - 1));
      state_nx = flip ? (state == STABLE_LO ? STABLE_HI : STABLE_LO) : state;
      cnt_nx   = (!differ || flip) ? '0 : cnt + CNT_W'(1);
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= STABLE_LO;
        cnt       <= '0;
        press     <= 1'b0;
        release_p <= 1'b0;
      end else begin
        state     <= state_nx;
        cnt       <= cnt_nx;
        press     <= flip && (state == STABLE_LO);
        release_p <= flip && (state == STABLE_HI);
      end
    end
    assign btn_level[i]   = state == STABLE_HI;
    assign btn_press[i]   = press;
    assign btn_release[i] = release_p;
`ifdef BTN_TOGGLE_EN
    logic tog;
    always_ff @(posedge clk) begin
      if (rst) tog <= 1'b0;
      else     tog <= tog ^ press;
    end
    assign btn_toggle[i] = tog;
`else
    assign btn_toggle[i] = 1'b0;
`endif
  end
endmodule
